// File: rtl/mul_ctrl_pkg.sv
// mul_ctrl_pkg: shared op/state encodings and handshake constants for the multiply sequencer
package mul_ctrl_pkg;
    typedef enum logic [2:0] {
        OP_NOP, OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
    } op_e;
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_DRAIN} state_e;
    localparam logic MUL_START = 1'b1;
    localparam logic MUL_STOP = 1'b0;
    localparam logic MUL_RESULT_READY = 1'b1;
    localparam logic MUL_RESULT_NOT_READY = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0;
    function automatic logic op_signed(op_e op);
        return op inside {OP_MULT, OP_MUL, OP_MADD, OP_MSUB};
    endfunction
endpackage

// File: rtl/mul_ctrl_if.sv
// mul_ctrl_if: ID/EX request, multiplier handshake and EX/MEM write bundle
interface mul_ctrl_if;
    logic [2:0]  op_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  waddr_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        flush_i;
    logic        stall_req_o;
    logic        mul_start_o;
    logic        mul_signed_o;
    logic [31:0] mul_a_o;
    logic [31:0] mul_b_o;
    logic        mul_ready_i;
    logic [63:0] mul_result_i;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        gpr_we_o;
    logic [4:0]  gpr_waddr_o;
    logic [31:0] gpr_wdata_o;
    modport slave (
        input  op_i, reg1_i, reg2_i, waddr_i, hi_i, lo_i, flush_i, mul_ready_i, mul_result_i,
        output stall_req_o, mul_start_o, mul_signed_o, mul_a_o, mul_b_o,
               hilo_we_o, hi_o, lo_o, gpr_we_o, gpr_waddr_o, gpr_wdata_o
    );
    modport master (
        output op_i, reg1_i, reg2_i, waddr_i, hi_i, lo_i, flush_i, mul_ready_i, mul_result_i,
        input  stall_req_o, mul_start_o, mul_signed_o, mul_a_o, mul_b_o,
               hilo_we_o, hi_o, lo_o, gpr_we_o, gpr_waddr_o, gpr_wdata_o
    );
endinterface

// File: rtl/mul_ctrl_acc.sv
// mul_acc: pass, accumulate or subtract the product against the latched HI/LO
module mul_acc
    import mul_ctrl_pkg::*;
(
    input  op_e         op,
    input  logic [63:0] hilo,
    input  logic [63:0] product,
    output logic [63:0] result
);
    // MADD* add, MSUB* subtract, everything else passes the product through
    always_comb
        result = (op == OP_MADD || op == OP_MADDU) ? hilo + product :
                 (op == OP_MSUB || op == OP_MSUBU) ? hilo - product : product;
endmodule

// File: rtl/mul_ctrl.sv
// mul_ctrl: EX-stage sequencer driving the multi-cycle multiplier and HI/LO/GPR writeback
module mul_ctrl
    import mul_ctrl_pkg::*;
(
    input logic clk,
    input logic rst,
    mul_ctrl_if.slave bus
);
    state_e      state;
    op_e         op_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [4:0]  waddr_q;
    logic [63:0] acc;
    op_e         op_in;

    assign op_in = op_e'(bus.op_i);

    mul_acc u_acc (
        .op     (op_q),
        .hilo   ({hi_q, lo_q}),
        .product(bus.mul_result_i),
        .result (acc)
    );

    // hold the pipeline while an op waits or runs, or while a flushed op drains
    assign bus.stall_req_o = !bus.flush_i && state != S_DONE &&
                             ((op_in != OP_NOP && (state == S_IDLE || state == S_BUSY)) || state == S_DRAIN);

    // sequencer: accept, wait for product, write one cycle, or drain a flushed op
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            op_q             <= OP_NOP;
            hi_q             <= ZERO_WORD;
            lo_q             <= ZERO_WORD;
            waddr_q          <= 5'd0;
            bus.mul_start_o  <= MUL_STOP;
            bus.mul_signed_o <= 1'b0;
            bus.mul_a_o      <= ZERO_WORD;
            bus.mul_b_o      <= ZERO_WORD;
            bus.hilo_we_o    <= 1'b0;
            bus.hi_o         <= ZERO_WORD;
            bus.lo_o         <= ZERO_WORD;
            bus.gpr_we_o     <= 1'b0;
            bus.gpr_waddr_o  <= 5'd0;
            bus.gpr_wdata_o  <= ZERO_WORD;
        end else begin
            bus.hilo_we_o <= 1'b0;
            bus.gpr_we_o  <= 1'b0;
            case (state)
                S_IDLE:
                    if (op_in != OP_NOP && !bus.flush_i && bus.mul_ready_i == MUL_RESULT_NOT_READY) begin
                        state            <= S_BUSY;
                        op_q             <= op_in;
                        hi_q             <= bus.hi_i;
                        lo_q             <= bus.lo_i;
                        waddr_q          <= bus.waddr_i;
                        bus.mul_a_o      <= bus.reg1_i;
                        bus.mul_b_o      <= bus.reg2_i;
                        bus.mul_signed_o <= op_signed(op_in);
                        bus.mul_start_o  <= MUL_START;
                    end
                S_BUSY:
                    if (bus.flush_i) begin
                        state           <= S_DRAIN;
                        bus.mul_start_o <= MUL_STOP;
                    end else if (bus.mul_ready_i == MUL_RESULT_READY) begin
                        state           <= S_DONE;
                        bus.mul_start_o <= MUL_STOP;
                        if (op_q == OP_MUL) begin
                            bus.gpr_we_o    <= 1'b1;
                            bus.gpr_waddr_o <= waddr_q;
                            bus.gpr_wdata_o <= bus.mul_result_i[31:0];
                        end else begin
                            bus.hilo_we_o <= 1'b1;
                            {bus.hi_o, bus.lo_o} <= acc;
                        end
                    end
                S_DONE:
                    state <= S_IDLE;
                S_DRAIN:
                    if (bus.mul_ready_i == MUL_RESULT_READY)
                        state <= S_IDLE;
                default:
                    state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: scoreboard bench with a multiplier model and an arithmetic reference
module tb_mul_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_ctrl_if bus();
    mul_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          is_gpr;
        logic [63:0] hilo;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] product(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        return sgn ? 64'(sa * sb) : {32'd0, a} * {32'd0, b};
    endfunction

    function automatic bit is_signed_op(input logic [2:0] op);
        return op == 3'd1 || op == 3'd3 || op == 3'd4 || op == 3'd6;
    endfunction

    function automatic exp_t ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                       input logic [4:0] wa, input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        logic [63:0] p;
        p = product(is_signed_op(op), a, b);
        e.is_gpr = (op == 3'd3);
        e.waddr = wa;
        e.wdata = p[31:0];
        e.hilo = (op == 3'd4 || op == 3'd5) ? {h, l} + p :
                 (op == 3'd6 || op == 3'd7) ? {h, l} - p : p;
        return e;
    endfunction

    // multiplier model: run for lat cycles, hold ready until start is seen low
    int lat = 3;
    int cnt = 0;
    int mst = 0;
    logic m_ready = 1'b0;
    logic ready_hold = 1'b0;
    logic [63:0] m_prod = 64'd0;
    assign bus.mul_ready_i = m_ready | ready_hold;
    assign bus.mul_result_i = m_prod;
    always @(posedge clk) begin
        if (rst) begin
            mst <= 0;
            m_ready <= 1'b0;
        end else if (mst == 0) begin
            if (bus.mul_start_o) begin
                mst <= 1;
                cnt <= lat;
                m_prod <= product(bus.mul_signed_o, bus.mul_a_o, bus.mul_b_o);
            end
        end else if (mst == 1) begin
            if (cnt <= 1) begin
                mst <= 2;
                m_ready <= 1'b1;
            end else
                cnt <= cnt - 1;
        end else if (!bus.mul_start_o) begin
            mst <= 0;
            m_ready <= 1'b0;
        end
    end

    // monitor: compare every write strobe against the oldest queued expectation
    bit exp_sgn = 1'b0;
    logic prev_start = 1'b0, prev_ready = 1'b0, prev_strobe = 1'b0;
    logic [63:0] last_hilo = 64'd0;
    logic [4:0] last_waddr = 5'd0;
    logic [31:0] last_wdata = 32'd0;
    exp_t e;
    always @(negedge clk) begin
        if (rst) begin
            last_hilo = 64'd0;
            last_waddr = 5'd0;
            last_wdata = 32'd0;
        end else begin
            if (bus.mul_start_o && !prev_start) chk("start_after_ready_low", 64'(prev_ready), 64'd0);
            if (bus.mul_start_o) chk("mul_signed", 64'(bus.mul_signed_o), 64'(exp_sgn));
            if (bus.hilo_we_o || bus.gpr_we_o) begin
                chk("strobe_one_cycle", 64'(prev_strobe), 64'd0);
                chk("stall_in_done", 64'(bus.stall_req_o), 64'd0);
                if (q.size() == 0)
                    chk("unexpected_write", 64'({bus.hilo_we_o, bus.gpr_we_o}), 64'd0);
                else begin
                    e = q.pop_front();
                    chk("gpr_we", 64'(bus.gpr_we_o), 64'(e.is_gpr));
                    chk("hilo_we", 64'(bus.hilo_we_o), 64'(!e.is_gpr));
                    if (e.is_gpr) begin
                        chk("gpr_waddr", 64'(bus.gpr_waddr_o), 64'(e.waddr));
                        chk("gpr_wdata", 64'(bus.gpr_wdata_o), 64'(e.wdata));
                        chk("hilo_held", {bus.hi_o, bus.lo_o}, last_hilo);
                        last_waddr = e.waddr;
                        last_wdata = e.wdata;
                    end else begin
                        chk("hilo_data", {bus.hi_o, bus.lo_o}, e.hilo);
                        chk("gpr_held", 64'({bus.gpr_waddr_o, bus.gpr_wdata_o}), 64'({last_waddr, last_wdata}));
                        last_hilo = e.hilo;
                    end
                end
            end
        end
        prev_start = bus.mul_start_o;
        prev_ready = bus.mul_ready_i;
        prev_strobe = bus.hilo_we_o | bus.gpr_we_o;
    end

    task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa,
                           input logic [31:0] h, input logic [31:0] l, input int latency, input bit push);
        bus.op_i = op;
        bus.reg1_i = a;
        bus.reg2_i = b;
        bus.waddr_i = wa;
        bus.hi_i = h;
        bus.lo_i = l;
        lat = latency;
        exp_sgn = is_signed_op(op);
        if (push) q.push_back(ref_model(op, a, b, wa, h, l));
    endtask

    task automatic advance();
        bit done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            #1;
            done = !bus.stall_req_o;
            @(posedge clk);
            @(negedge clk);
        end
        if (!done) chk("advance_timeout", 64'(bus.stall_req_o), 64'd0);
        bus.op_i = 3'd0;
    endtask

    task automatic wait_start();
        for (int n = 0; n < 50 && !bus.mul_start_o; n++) @(negedge clk);
        chk("start_seen", 64'(bus.mul_start_o), 64'd1);
    endtask

    task automatic check_zero(input string tag);
        #1;
        chk({tag, "_start"}, 64'(bus.mul_start_o), 64'd0);
        chk({tag, "_signed"}, 64'(bus.mul_signed_o), 64'd0);
        chk({tag, "_ab"}, {bus.mul_a_o, bus.mul_b_o}, 64'd0);
        chk({tag, "_we"}, 64'({bus.hilo_we_o, bus.gpr_we_o}), 64'd0);
        chk({tag, "_hilo"}, {bus.hi_o, bus.lo_o}, 64'd0);
        chk({tag, "_gpr"}, 64'({bus.gpr_waddr_o, bus.gpr_wdata_o}), 64'd0);
        chk({tag, "_stall"}, 64'(bus.stall_req_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.op_i = 3'd0;
        bus.reg1_i = 32'd0;
        bus.reg2_i = 32'd0;
        bus.waddr_i = 5'd0;
        bus.hi_i = 32'd0;
        bus.lo_i = 32'd0;
        bus.flush_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_zero("reset");
        @(negedge clk);
        present(3'd1, 32'hFFFFFFFD, 32'd5, 5'd0, 32'd0, 32'd0, 3, 1'b1);
        advance();
        present(3'd2, 32'hFFFFFFFF, 32'd2, 5'd0, 32'd0, 32'd0, 4, 1'b1);
        advance();
        present(3'd4, 32'd3, 32'd4, 5'd0, 32'd0, 32'd10, 2, 1'b1);
        advance();
        present(3'd7, 32'd2, 32'd3, 5'd0, 32'd0, 32'd5, 1, 1'b1);
        advance();
        present(3'd3, 32'd7, 32'd6, 5'd9, 32'd0, 32'd0, 3, 1'b1);
        advance();
        ready_hold = 1'b1;
        present(3'd2, 32'd9, 32'd9, 5'd0, 32'd0, 32'd0, 2, 1'b1);
        repeat (3) begin
            #1;
            chk("no_accept_while_ready", 64'(bus.mul_start_o), 64'd0);
            chk("stall_while_ready", 64'(bus.stall_req_o), 64'd1);
            @(negedge clk);
        end
        ready_hold = 1'b0;
        advance();
        present(3'd1, 32'h11, 32'h22, 5'd0, 32'd0, 32'd0, 20, 1'b0);
        wait_start();
        repeat (5) @(negedge clk);
        bus.flush_i = 1'b1;
        #1;
        chk("flush_stall_low", 64'(bus.stall_req_o), 64'd0);
        @(negedge clk);
        bus.flush_i = 1'b0;
        bus.op_i = 3'd0;
        for (int n = 0; n < 50 && !bus.mul_ready_i; n++) begin
            #1;
            chk("drain_start_low", 64'(bus.mul_start_o), 64'd0);
            chk("drain_stall", 64'(bus.stall_req_o), 64'd1);
            @(negedge clk);
        end
        chk("drain_ready", 64'(bus.mul_ready_i), 64'd1);
        @(negedge clk);
        #1;
        chk("drain_exit", 64'(bus.stall_req_o), 64'd0);
        @(negedge clk);
        present(3'd1, 32'd2, 32'd3, 5'd0, 32'd0, 32'd0, 2, 1'b1);
        advance();
        present(3'd1, 32'd100, 32'd200, 5'd0, 32'd0, 32'd0, 2, 1'b1);
        advance();
        present(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'd0, 32'd0, 1, 1'b1);
        advance();
        present(3'd1, 32'd5, 32'd5, 5'd0, 32'd0, 32'd0, 10, 1'b0);
        wait_start();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.op_i = 3'd0;
        check_zero("busy_reset");
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            present(3'($urandom_range(1, 7)), $urandom, $urandom, 5'($urandom), $urandom, $urandom,
                    $urandom_range(1, 8), 1'b1);
            advance();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
